// File: rtl/io_input_responder.sv
// Memory-mapped switch/push-button peripheral: two-flop synchronisers, per-bit
// debounce, sticky key-press flags and a press counter behind a 1-cycle registered read port.
module io_input_responder #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        we,
    input  logic [9:0]  sw,
    input  logic [3:1]  key,
    output logic [31:0] dataout,
    output logic        hit,
    output logic        irq
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned NB = 13;
    // Bits 12:10 are the active-low keys, so their idle level is 1.
    localparam logic [NB-1:0] IDLE_VAL = {3'b111, 10'b0};
    localparam logic [CW-1:0] TC       = CW'(DEB_CYCLES - 1);

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q, sync2_q;
    logic [NB-1:0] db_q, db_d;
    logic [CW-1:0] dcnt_q [NB];
    logic [CW-1:0] dcnt_d [NB];
    logic [3:1]    kedge_q, kedge_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   dataout_q, dataout_d;
    logic          hit_q;

    logic          sel;
    logic [3:1]    press;
    logic [1:0]    npress;
    logic          clr_edge, ld_cnt;
    logic          unused_bits;

    assign raw         = {key, sw};
    assign sel         = (addr[31:4] == 28'h000000C);
    assign clr_edge    = we && sel && (addr[3:2] == 2'd2);
    assign ld_cnt      = we && sel && (addr[3:2] == 2'd3);
    assign unused_bits = ^{addr[1:0], datain[31:4], datain[0]};

    always_comb begin
        for (int i = 0; i < int'(NB); i++) begin
            db_d[i]   = db_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dcnt_q[i] == TC) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + CW'(1);
                end
            end
        end
    end

    // A press is the debounced key level falling; a release never counts.
    assign press  = db_q[12:10] & ~db_d[12:10];
    assign npress = {1'b0, press[1]} + {1'b0, press[2]} + {1'b0, press[3]};

    always_comb begin
        kedge_d = (kedge_q & ~(clr_edge ? datain[3:1] : 3'b000)) | press;
        cnt_d   = ld_cnt ? {14'b0, npress} : cnt_q + {14'b0, npress};
    end

    always_comb begin
        dataout_d = '0;
        if (sel) begin
            unique case (addr[3:2])
                2'd0: dataout_d = {22'b0, db_q[9:0]};
                2'd1: dataout_d = {29'b0, ~db_q[12:10]};
                2'd2: dataout_d = {29'b0, kedge_q};
                2'd3: dataout_d = {16'b0, cnt_q};
                default: dataout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= IDLE_VAL;
            sync2_q   <= IDLE_VAL;
            db_q      <= IDLE_VAL;
            for (int i = 0; i < int'(NB); i++) dcnt_q[i] <= '0;
            kedge_q   <= '0;
            cnt_q     <= '0;
            dataout_q <= '0;
            hit_q     <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            for (int i = 0; i < int'(NB); i++) dcnt_q[i] <= dcnt_d[i];
            kedge_q   <= kedge_d;
            cnt_q     <= cnt_d;
            dataout_q <= dataout_d;
            hit_q     <= sel;
        end
    end

    assign dataout = dataout_q;
    assign hit     = hit_q;
    assign irq     = |kedge_q;

endmodule
